// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection: one-cycle capture, bubbles on flush or load-use.
// Stall is combinational and holds PC and IF/ID for LOAD_USE_STALL cycles per hazard; Flush overrides any stall.
module id_ex_reg #(
  parameter int LOAD_USE_STALL = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IDin_PC4,
  input  logic [31:0] IDin_Jtarg,
  input  logic [31:0] IDin_busA,
  input  logic [31:0] IDin_busB,
  input  logic [4:0]  IDin_Rs,
  input  logic [4:0]  IDin_Rt,
  input  logic [4:0]  IDin_Rd,
  input  logic [5:0]  IDin_func,
  input  logic [15:0] IDin_immd,
  input  logic        IDin_RegWr,
  input  logic        IDin_ALUSrc,
  input  logic        IDin_RegDst,
  input  logic        IDin_MemtoReg,
  input  logic        IDin_MemWr,
  input  logic        IDin_Branch,
  input  logic        IDin_Jump,
  input  logic        IDin_ExtOp,
  input  logic        IDin_R_type,
  input  logic [2:0]  IDin_ALUop,
  input  logic        IDin_Valid,
  input  logic        Flush,
  output logic [31:0] EXin_PC4,
  output logic [31:0] EXin_Jtarg,
  output logic [31:0] EXin_busA,
  output logic [31:0] EXin_busB,
  output logic [4:0]  EXin_Rs,
  output logic [4:0]  EXin_Rt,
  output logic [4:0]  EXin_Rd,
  output logic [5:0]  EXin_func,
  output logic [15:0] EXin_immd,
  output logic        EXin_RegWr,
  output logic        EXin_ALUSrc,
  output logic        EXin_RegDst,
  output logic        EXin_MemtoReg,
  output logic        EXin_MemWr,
  output logic        EXin_Branch,
  output logic        EXin_Jump,
  output logic        EXin_ExtOp,
  output logic        EXin_R_type,
  output logic [2:0]  EXin_ALUop,
  output logic        EX_Valid,
  output logic        Stall
);

  localparam logic [1:0] STALL_RELOAD = 2'(LOAD_USE_STALL - 1);

  logic [31:0] r_pc4, r_jtarg, r_busa, r_busb;
  logic [4:0]  r_rs, r_rt, r_rd;
  logic [5:0]  r_func;
  logic [15:0] r_immd;
  logic        r_regwr, r_alusrc, r_regdst, r_memtoreg, r_memwr;
  logic        r_branch, r_jump, r_extop, r_rtype;
  logic [2:0]  r_aluop;
  logic        r_valid;
  logic [1:0]  r_cnt;

  logic [4:0]  w_rw_ex;
  logic        w_uses_rt;
  logic        w_load_use;
  logic        w_bubble;

  // Destination of the instruction now in EX; $0 is excluded since it is never written.
  assign w_rw_ex    = r_regdst ? r_rd : r_rt;
  assign w_uses_rt  = IDin_R_type | IDin_MemWr | IDin_Branch;
  assign w_load_use = r_valid & r_memtoreg & r_regwr & IDin_Valid & (w_rw_ex != 5'd0) &
                      ((w_rw_ex == IDin_Rs) | (w_uses_rt & (w_rw_ex == IDin_Rt)));
  assign Stall      = !Flush & ((w_load_use & (r_cnt == 2'd0)) | (r_cnt != 2'd0));
  assign w_bubble   = Flush | w_load_use | (r_cnt != 2'd0);

  // Data fields hold through bubbles; only control and valid are squashed.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc4   <= '0;
      r_jtarg <= '0;
      r_busa  <= '0;
      r_busb  <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_func  <= '0;
      r_immd  <= '0;
    end else if (!w_bubble) begin
      r_pc4   <= IDin_PC4;
      r_jtarg <= IDin_Jtarg;
      r_busa  <= IDin_busA;
      r_busb  <= IDin_busB;
      r_rs    <= IDin_Rs;
      r_rt    <= IDin_Rt;
      r_rd    <= IDin_Rd;
      r_func  <= IDin_func;
      r_immd  <= IDin_immd;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_regwr    <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regdst   <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memwr    <= 1'b0;
      r_branch   <= 1'b0;
      r_jump     <= 1'b0;
      r_extop    <= 1'b0;
      r_rtype    <= 1'b0;
      r_aluop    <= 3'd0;
      r_valid    <= 1'b0;
    end else if (w_bubble) begin
      r_regwr    <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regdst   <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memwr    <= 1'b0;
      r_branch   <= 1'b0;
      r_jump     <= 1'b0;
      r_extop    <= 1'b0;
      r_rtype    <= 1'b0;
      r_aluop    <= 3'd0;
      r_valid    <= 1'b0;
    end else begin
      // An empty ID slot must not carry write enables into EX.
      r_regwr    <= IDin_RegWr    & IDin_Valid;
      r_alusrc   <= IDin_ALUSrc   & IDin_Valid;
      r_regdst   <= IDin_RegDst   & IDin_Valid;
      r_memtoreg <= IDin_MemtoReg & IDin_Valid;
      r_memwr    <= IDin_MemWr    & IDin_Valid;
      r_branch   <= IDin_Branch   & IDin_Valid;
      r_jump     <= IDin_Jump     & IDin_Valid;
      r_extop    <= IDin_ExtOp    & IDin_Valid;
      r_rtype    <= IDin_R_type   & IDin_Valid;
      r_aluop    <= IDin_Valid ? IDin_ALUop : 3'd0;
      r_valid    <= IDin_Valid;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      r_cnt <= 2'd0;
    else if (Flush)
      r_cnt <= 2'd0;
    else if (w_load_use && (r_cnt == 2'd0))
      r_cnt <= STALL_RELOAD;
    else if (r_cnt != 2'd0)
      r_cnt <= r_cnt - 2'd1;
  end

  assign EXin_PC4      = r_pc4;
  assign EXin_Jtarg    = r_jtarg;
  assign EXin_busA     = r_busa;
  assign EXin_busB     = r_busb;
  assign EXin_Rs       = r_rs;
  assign EXin_Rt       = r_rt;
  assign EXin_Rd       = r_rd;
  assign EXin_func     = r_func;
  assign EXin_immd     = r_immd;
  assign EXin_RegWr    = r_regwr;
  assign EXin_ALUSrc   = r_alusrc;
  assign EXin_RegDst   = r_regdst;
  assign EXin_MemtoReg = r_memtoreg;
  assign EXin_MemWr    = r_memwr;
  assign EXin_Branch   = r_branch;
  assign EXin_Jump     = r_jump;
  assign EXin_ExtOp    = r_extop;
  assign EXin_R_type   = r_rtype;
  assign EXin_ALUop    = r_aluop;
  assign EX_Valid      = r_valid;

endmodule
